// File: rtl/qspi_arb_pkg.sv
// -----------------------------------------------------------------------------
// qspi_arb_pkg
// Shared definitions for the QSPI command arbiter: requester/owner encodings,
// arbiter state encodings, the default descriptor width and a helper that
// sizes the starvation counter.
// No ports (package).
// -----------------------------------------------------------------------------
package qspi_arb_pkg;

  // Default width of the packed command descriptor (opaque to the arbiter).
  localparam int DESC_W_DEFAULT = 96;

  // Which requester currently owns the command engine.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CSR  = 2'd1,
    OWN_XIP  = 2'd2
  } owner_e;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Starvation counter width: wide enough to hold starve_max, never below
  // three bits.
  function automatic int starve_width(input int starve_max);
    int w;
    w = $clog2(starve_max + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage : qspi_arb_pkg

// File: rtl/qspi_arb_watchdog.sv
// -----------------------------------------------------------------------------
// qspi_arb_watchdog
// Transaction watchdog for the command arbiter. Counts clock cycles while
// enabled, restarts from zero on clear, and flags the cycle in which the count
// reaches threshold-1 so the arbiter can register the abort on the next edge
// (abort lands exactly `threshold` cycles after counting started).
// A threshold of zero disables the expire flag entirely.
//
// Ports:
//   clk        in   1     system clock
//   reset      in   1     asynchronous active-high reset
//   clr        in   1     synchronous clear of the count
//   en         in   1     count enable (one increment per cycle)
//   threshold  in   TO_W  timeout threshold in cycles, 0 = disabled
//   expire     out  1     high in the cycle the count equals threshold-1
// -----------------------------------------------------------------------------
module qspi_arb_watchdog #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic [TO_W-1:0] threshold,
  output logic            expire
);

  logic [TO_W-1:0] count_r;

  // Cycle counter: clear has priority over enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + TO_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Threshold compare; only meaningful while counting and when enabled.
  always_comb begin
    expire = 1'b0;
    if (en && (threshold != '0)) begin
      expire = (count_r == (threshold - TO_W'(1)));
    end else begin
      expire = 1'b0;
    end
  end

endmodule : qspi_arb_watchdog

// File: rtl/qspi_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// qspi_cmd_arbiter
// Shares the single QSPI command engine between the CSR command path and the
// XIP read path. In IDLE it picks a winner (XIP by default, CSR when it is the
// only requester or has been passed over STARVE_MAX times in a row), latches
// the winner's descriptor, pulses start/ack for one cycle, then waits for the
// engine's done or a watchdog timeout and routes the matching strobe back to
// the owning requester.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   csr_req_i / csr_desc_i     CSR request level and descriptor
//   csr_ack_o/done_o/err_o     CSR accept, completion and timeout pulses
//   xip_req_i / xip_desc_i     XIP request level and descriptor
//   xip_ack_o/done_o/err_o     XIP accept, completion and timeout pulses
//   timeout_i                  watchdog threshold in cycles, 0 disables
//   eng_start_o                one-cycle start pulse to the engine
//   eng_desc_o                 latched descriptor, held until next grant
//   eng_busy_i                 engine busy, blocks new grants
//   eng_done_i                 engine completion pulse
//   eng_abort_o                forces the engine idle on timeout
//   owner_o                    0 none, 1 CSR, 2 XIP
//   busy_o                     high whenever the arbiter is not IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module qspi_cmd_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int DESC_W     = DESC_W_DEFAULT,
  parameter int STARVE_MAX = 4,
  parameter int TO_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  // CSR requester
  input  logic              csr_req_i,
  input  logic [DESC_W-1:0] csr_desc_i,
  output logic              csr_ack_o,
  output logic              csr_done_o,
  output logic              csr_err_o,
  // XIP requester
  input  logic              xip_req_i,
  input  logic [DESC_W-1:0] xip_desc_i,
  output logic              xip_ack_o,
  output logic              xip_done_o,
  output logic              xip_err_o,
  // configuration
  input  logic [TO_W-1:0]   timeout_i,
  // engine side
  output logic              eng_start_o,
  output logic [DESC_W-1:0] eng_desc_o,
  input  logic              eng_busy_i,
  input  logic              eng_done_i,
  output logic              eng_abort_o,
  // status
  output logic [1:0]        owner_o,
  output logic              busy_o
);

  localparam int            SW         = starve_width(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_e            state_r;
  owner_e            owner_r;
  logic [SW-1:0]     starve_r;
  logic [DESC_W-1:0] desc_r;
  logic              busy_r;
  logic              eng_start_r;
  logic              eng_abort_r;
  logic              csr_ack_r;
  logic              csr_done_r;
  logic              csr_err_r;
  logic              xip_ack_r;
  logic              xip_done_r;
  logic              xip_err_r;

  logic              grant;
  logic              csr_wins;
  logic [SW-1:0]     starve_nxt;
  logic              wd_clr;
  logic              wd_en;
  logic              wd_expire;

  // The watchdog restarts during ISSUE so WAIT always begins at count zero.
  assign wd_clr = (state_r == ST_ISSUE);
  assign wd_en  = (state_r == ST_WAIT);

  qspi_arb_watchdog #(
    .TO_W (TO_W)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clr       (wd_clr),
    .en        (wd_en),
    .threshold (timeout_i),
    .expire    (wd_expire)
  );

  // Arbitration decision and next starvation count; only consumed in IDLE.
  always_comb begin
    grant      = 1'b0;
    csr_wins   = 1'b0;
    starve_nxt = starve_r;
    if (!eng_busy_i && (csr_req_i || xip_req_i)) begin
      grant = 1'b1;
      if (csr_req_i && (!xip_req_i || (starve_r == STARVE_LIM))) begin
        // CSR alone, or CSR has waited out its allowance of XIP grants.
        csr_wins   = 1'b1;
        starve_nxt = '0;
      end else if (csr_req_i) begin
        // XIP wins over a waiting CSR: count the pass-over, saturating.
        csr_wins   = 1'b0;
        starve_nxt = (starve_r == STARVE_LIM) ? starve_r : (starve_r + SW'(1));
      end else begin
        // XIP wins with nobody waiting.
        csr_wins   = 1'b0;
        starve_nxt = '0;
      end
    end else begin
      grant      = 1'b0;
      csr_wins   = 1'b0;
      starve_nxt = starve_r;
    end
  end

  // Arbiter FSM with all outputs registered; strobes default low each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      owner_r     <= OWN_NONE;
      starve_r    <= '0;
      desc_r      <= '0;
      busy_r      <= 1'b0;
      eng_start_r <= 1'b0;
      eng_abort_r <= 1'b0;
      csr_ack_r   <= 1'b0;
      csr_done_r  <= 1'b0;
      csr_err_r   <= 1'b0;
      xip_ack_r   <= 1'b0;
      xip_done_r  <= 1'b0;
      xip_err_r   <= 1'b0;
    end else begin
      eng_start_r <= 1'b0;
      eng_abort_r <= 1'b0;
      csr_ack_r   <= 1'b0;
      csr_done_r  <= 1'b0;
      csr_err_r   <= 1'b0;
      xip_ack_r   <= 1'b0;
      xip_done_r  <= 1'b0;
      xip_err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant) begin
            // Start and ack are registered here so they appear in ISSUE.
            state_r     <= ST_ISSUE;
            busy_r      <= 1'b1;
            eng_start_r <= 1'b1;
            csr_ack_r   <= csr_wins;
            xip_ack_r   <= ~csr_wins;
            owner_r     <= csr_wins ? OWN_CSR : OWN_XIP;
            desc_r      <= csr_wins ? csr_desc_i : xip_desc_i;
            starve_r    <= starve_nxt;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done_i) begin
            // Completion beats a same-cycle timeout.
            csr_done_r <= (owner_r == OWN_CSR);
            xip_done_r <= (owner_r == OWN_XIP);
            owner_r    <= OWN_NONE;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else if (wd_expire) begin
            eng_abort_r <= 1'b1;
            csr_err_r   <= (owner_r == OWN_CSR);
            xip_err_r   <= (owner_r == OWN_XIP);
            owner_r     <= OWN_NONE;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean idle.
          state_r <= ST_IDLE;
          owner_r <= OWN_NONE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign eng_start_o = eng_start_r;
  assign eng_abort_o = eng_abort_r;
  assign eng_desc_o  = desc_r;
  assign csr_ack_o   = csr_ack_r;
  assign csr_done_o  = csr_done_r;
  assign csr_err_o   = csr_err_r;
  assign xip_ack_o   = xip_ack_r;
  assign xip_done_o  = xip_done_r;
  assign xip_err_o   = xip_err_r;
  assign owner_o     = owner_r;
  assign busy_o      = busy_r;

endmodule : qspi_cmd_arbiter

// File: tb/tb_qspi_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_qspi_cmd_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model predicts every output strobe and pushes it to a queue; a
// negedge monitor pops and compares whenever the DUT shows a strobe.
// -----------------------------------------------------------------------------
module tb_qspi_cmd_arbiter;
  import qspi_arb_pkg::*;

  localparam int DESC_W     = 96;
  localparam int STARVE_MAX = 4;
  localparam int TO_W       = 16;
  localparam int NEVER      = 32'h7fff_ffff;

  // strobe vector bit positions
  localparam int B_START    = 7;
  localparam int B_CSR_ACK  = 6;
  localparam int B_XIP_ACK  = 5;
  localparam int B_CSR_DONE = 4;
  localparam int B_XIP_DONE = 3;
  localparam int B_CSR_ERR  = 2;
  localparam int B_XIP_ERR  = 1;
  localparam int B_ABORT    = 0;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              csr_req_i = 1'b0;
  logic [DESC_W-1:0] csr_desc_i = '0;
  logic              csr_ack_o, csr_done_o, csr_err_o;
  logic              xip_req_i = 1'b0;
  logic [DESC_W-1:0] xip_desc_i = '0;
  logic              xip_ack_o, xip_done_o, xip_err_o;
  logic [TO_W-1:0]   timeout_i = '0;
  logic              eng_start_o;
  logic [DESC_W-1:0] eng_desc_o;
  logic              eng_busy_i = 1'b0;
  logic              eng_done_i = 1'b0;
  logic              eng_abort_o;
  logic [1:0]        owner_o;
  logic              busy_o;

  always #5 clk = ~clk;

  qspi_cmd_arbiter #(
    .DESC_W     (DESC_W),
    .STARVE_MAX (STARVE_MAX),
    .TO_W       (TO_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .csr_req_i   (csr_req_i),
    .csr_desc_i  (csr_desc_i),
    .csr_ack_o   (csr_ack_o),
    .csr_done_o  (csr_done_o),
    .csr_err_o   (csr_err_o),
    .xip_req_i   (xip_req_i),
    .xip_desc_i  (xip_desc_i),
    .xip_ack_o   (xip_ack_o),
    .xip_done_o  (xip_done_o),
    .xip_err_o   (xip_err_o),
    .timeout_i   (timeout_i),
    .eng_start_o (eng_start_o),
    .eng_desc_o  (eng_desc_o),
    .eng_busy_i  (eng_busy_i),
    .eng_done_i  (eng_done_i),
    .eng_abort_o (eng_abort_o),
    .owner_o     (owner_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    int                cyc;
    logic [7:0]        str;
    logic [1:0]        owner;
    logic              busy;
    logic [DESC_W-1:0] desc;
  } ev_t;

  ev_t        exp_q[$];
  logic [1:0] grant_log[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         strobe_cnt[8];
  int         last_start_cyc = -1;
  int         last_done_cyc = -1;
  int         last_abort_cyc = -1;

  // stimulus configuration
  bit                rst_cfg = 1'b1;
  int                mode_v[2];        // 0 off, 1 random, 2 constant high, 3 one-shot
  bit                shot_v[2];
  bit                drop_v[2];
  logic              req_v[2];
  logic [DESC_W-1:0] desc_v[2];
  logic [DESC_W-1:0] shot_desc[2];
  int                raise_cyc[2];
  int                eng_delay = -1;   // >0 fixed, <0 never, 0 random
  int                done_at = -1;
  int                busy_pct = 0;
  bit                busy_force = 1'b0;
  int                stray_pct = 0;

  // reference model state
  int                m_idle_from = 0;
  int                m_wait_from = 0;
  int                m_starve = 0;
  int                m_owner = 0;
  logic [DESC_W-1:0] m_desc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic [7:0] s, input int own, input logic bsy);
    ev_t e;
    e.cyc   = c;
    e.str   = s;
    e.owner = 2'(own);
    e.busy  = bsy;
    e.desc  = m_desc;
    exp_q.push_back(e);
  endtask

  // Transaction-level prediction from the current cycle's inputs.
  task automatic model_step();
    bit cw;
    int k;
    if (!reset) begin
      if (cyc >= m_idle_from) begin
        if (!eng_busy_i && (csr_req_i || xip_req_i)) begin
          cw = csr_req_i && (!xip_req_i || (m_starve >= STARVE_MAX));
          if (cw) m_starve = 0;
          else if (csr_req_i) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
          else m_starve = 0;
          m_owner = cw ? 1 : 2;
          m_desc  = cw ? csr_desc_i : xip_desc_i;
          push_ev(cyc + 1, {1'b1, cw, ~cw, 5'b0}, m_owner, 1'b1);
          m_idle_from = NEVER;
          m_wait_from = cyc + 2;
        end
      end else if (cyc >= m_wait_from) begin
        k = cyc - m_wait_from;
        if (eng_done_i) begin
          push_ev(cyc + 1, {3'b0, m_owner == 1, m_owner == 2, 3'b0}, 0, 1'b0);
          m_idle_from = cyc + 1;
        end else if ((timeout_i != '0) && (k == int'(timeout_i) - 1)) begin
          push_ev(cyc + 1, {5'b0, m_owner == 1, m_owner == 2, 1'b1}, 0, 1'b0);
          m_idle_from = cyc + 1;
        end
      end
    end
  endtask

  // One clock of stimulus: drive inputs just after the edge, then predict.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst_cfg && !reset) begin
      exp_q.delete();
      m_idle_from = 0;
      m_starve    = 0;
      done_at     = -1;
      drop_v[0]   = 1'b0;
      drop_v[1]   = 1'b0;
    end
    reset = rst_cfg;
    if (!reset && eng_start_o) begin
      if (eng_delay > 0) done_at = cyc + eng_delay;
      else if (eng_delay < 0) done_at = -1;
      else if ((timeout_i != '0) && ($urandom_range(0, 9) == 0)) done_at = -1;
      else done_at = cyc + int'($urandom_range(1, 25));
    end
    eng_done_i = (cyc == done_at) || ((stray_pct > 0) && (int'($urandom_range(0, 99)) < stray_pct));
    eng_busy_i = busy_force || (int'($urandom_range(0, 99)) < busy_pct);
    for (int i = 0; i < 2; i++) begin
      case (mode_v[i])
        0: req_v[i] = 1'b0;
        2: req_v[i] = 1'b1;
        default: begin
          if (drop_v[i]) begin
            req_v[i]  = 1'b0;
            drop_v[i] = 1'b0;
          end else if (!req_v[i] && ((mode_v[i] == 1) ? ($urandom_range(0, 99) < 30) : !shot_v[i])) begin
            req_v[i]     = 1'b1;
            desc_v[i]    = (mode_v[i] == 1) ? {$urandom(), $urandom(), $urandom()} : shot_desc[i];
            shot_v[i]    = 1'b1;
            raise_cyc[i] = cyc;
          end
          if (!reset && ((i == 0) ? csr_ack_o : xip_ack_o)) drop_v[i] = 1'b1;
        end
      endcase
    end
    csr_req_i  = req_v[0];
    xip_req_i  = req_v[1];
    csr_desc_i = desc_v[0];
    xip_desc_i = desc_v[1];
    model_step();
  endtask

  task automatic new_phase(input int m0, input int m1, input int dly, input int tmo);
    mode_v[0] = m0;  mode_v[1] = m1;
    shot_v[0] = 1'b0; shot_v[1] = 1'b0;
    drop_v[0] = 1'b0; drop_v[1] = 1'b0;
    eng_delay = dly;
    timeout_i = TO_W'(tmo);
    for (int i = 0; i < 8; i++) strobe_cnt[i] = 0;
  endtask

  task automatic drain(input string name, input int bound);
    int n;
    n = 0;
    mode_v[0] = 0;
    mode_v[1] = 0;
    while (((cyc < m_idle_from) || (exp_q.size() != 0) || csr_req_i || xip_req_i) && (n < bound)) begin
      step();
      n++;
    end
    step();
    step();
    if (n >= bound) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: arbiter still busy after %0d cycles, required idle", name, bound);
    end
  endtask

  // Monitor: every strobe the DUT shows must match the next predicted event.
  ev_t        mon_e;
  logic [7:0] mon_s;
  always @(negedge clk) begin
    if (!reset) begin
      while ((exp_q.size() > 0) && (exp_q[0].cyc < cyc)) begin
        mon_e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event: got no strobe, required %b at cycle %0d", mon_e.str, mon_e.cyc);
      end
      mon_s = {eng_start_o, csr_ack_o, xip_ack_o, csr_done_o, xip_done_o, csr_err_o, xip_err_o, eng_abort_o};
      if (mon_s != 8'd0) begin
        for (int i = 0; i < 8; i++) if (mon_s[i]) strobe_cnt[i]++;
        if (eng_start_o) begin
          grant_log.push_back(owner_o);
          last_start_cyc = cyc;
        end
        if (csr_done_o || xip_done_o) last_done_cyc = cyc;
        if (eng_abort_o) last_abort_cyc = cyc;
        if ((exp_q.size() == 0) || (exp_q[0].cyc != cyc)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got strobes %b at cycle %0d, required none", mon_s, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_strobes_owner_busy", 128'({mon_s, owner_o, busy_o}),
                128'({mon_e.str, mon_e.owner, mon_e.busy}));
          check("event_desc", 128'(eng_desc_o), 128'(mon_e.desc));
        end
      end
    end
  end

  int         exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
  int         rel;
  int         n;
  logic [DESC_W-1:0] a5_desc;

  initial begin
    for (int i = 0; i < 2; i++) begin
      mode_v[i] = 0; shot_v[i] = 1'b0; drop_v[i] = 1'b0; req_v[i] = 1'b0;
      desc_v[i] = '0; shot_desc[i] = '0; raise_cyc[i] = 0;
    end
    for (int i = 0; i < 8; i++) strobe_cnt[i] = 0;

    // reset state
    #2;
    check("reset_strobes", 128'({eng_start_o, csr_ack_o, xip_ack_o, csr_done_o, xip_done_o,
                                 csr_err_o, xip_err_o, eng_abort_o, owner_o, busy_o}), 128'(0));
    check("reset_desc", 128'(eng_desc_o), 128'(0));
    step();
    step();
    rst_cfg = 1'b0;
    step();

    // CSR only, descriptor ending A5, done 20 cycles after start
    a5_desc = {$urandom(), $urandom(), 24'h3c5a96, 8'hA5};
    shot_desc[0] = a5_desc;
    new_phase(3, 0, 20, 0);
    for (int i = 0; i < 30; i++) step();
    drain("csr_only", 100);
    check("csr_only_start_lat", 128'(last_start_cyc), 128'(raise_cyc[0] + 1));
    check("csr_only_done_lat", 128'(last_done_cyc), 128'(last_start_cyc + 21));
    check("csr_only_done_cnt", 128'(strobe_cnt[B_CSR_DONE]), 128'(1));
    check("csr_only_xip_quiet", 128'(strobe_cnt[B_XIP_ACK] + strobe_cnt[B_XIP_DONE] + strobe_cnt[B_XIP_ERR]), 128'(0));
    check("csr_only_desc_held", 128'(eng_desc_o), 128'(a5_desc));

    // both requesting continuously: starvation pattern
    desc_v[0] = {$urandom(), $urandom(), $urandom()};
    desc_v[1] = {$urandom(), $urandom(), $urandom()};
    grant_log.delete();
    new_phase(2, 2, 5, 0);
    n = 0;
    while ((grant_log.size() < 10) && (n < 400)) begin
      step();
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL starve_grants: got %0d grants, required 10", grant_log.size());
    end
    drain("starve", 100);
    for (int i = 0; i < 10; i++) begin
      if (i < grant_log.size()) check($sformatf("starve_order_%0d", i), 128'(grant_log[i]), 128'(exp_order[i]));
    end

    // timeout 10, engine never completes
    shot_desc[1] = {$urandom(), $urandom(), $urandom()};
    new_phase(0, 3, -1, 10);
    for (int i = 0; i < 20; i++) step();
    drain("timeout", 100);
    check("timeout_abort_lat", 128'(last_abort_cyc), 128'(last_start_cyc + 11));
    check("timeout_err_cnt", 128'({strobe_cnt[B_XIP_ERR], strobe_cnt[B_ABORT]}), 128'({32'd1, 32'd1}));
    check("timeout_no_done", 128'(strobe_cnt[B_XIP_DONE] + strobe_cnt[B_CSR_ERR]), 128'(0));

    // timeout 10, done on the 10th WAIT cycle: done wins
    new_phase(0, 3, 10, 10);
    for (int i = 0; i < 20; i++) step();
    drain("done_vs_timeout", 100);
    check("done_wins_cnt", 128'({strobe_cnt[B_XIP_DONE], strobe_cnt[B_XIP_ERR], strobe_cnt[B_ABORT]}),
          128'({32'd1, 32'd0, 32'd0}));
    check("done_wins_lat", 128'(last_done_cyc), 128'(last_start_cyc + 11));

    // timeout 10, done one cycle too late: timeout wins, late done ignored
    new_phase(0, 3, 11, 10);
    for (int i = 0; i < 20; i++) step();
    drain("late_done", 100);
    check("late_done_cnt", 128'({strobe_cnt[B_XIP_DONE], strobe_cnt[B_ABORT]}), 128'({32'd0, 32'd1}));

    // engine busy blocks the grant until it falls
    new_phase(0, 3, 4, 0);
    busy_force = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("busy_no_grant", 128'(strobe_cnt[B_START]), 128'(0));
    busy_force = 1'b0;
    step();
    rel = cyc;
    drain("busy", 100);
    check("busy_release_lat", 128'(last_start_cyc), 128'(rel + 1));

    // reset mid-WAIT with CSR owner and XIP pending
    new_phase(3, 0, -1, 0);
    for (int i = 0; i < 6; i++) step();
    mode_v[1] = 3;
    step();
    rst_cfg = 1'b1;
    step();
    #1;
    check("midreset_strobes", 128'({eng_start_o, csr_ack_o, xip_ack_o, csr_done_o, xip_done_o,
                                    csr_err_o, xip_err_o, eng_abort_o, owner_o, busy_o}), 128'(0));
    check("midreset_desc", 128'(eng_desc_o), 128'(0));
    step();
    step();
    eng_delay = 4;
    rst_cfg = 1'b0;
    step();
    rel = cyc;
    drain("post_reset", 100);
    check("post_reset_start_lat", 128'(last_start_cyc), 128'(rel + 1));
    check("post_reset_owner", 128'(grant_log[grant_log.size() - 1]), 128'(2));
    check("post_reset_no_csr_strobe", 128'(strobe_cnt[B_CSR_DONE] + strobe_cnt[B_CSR_ERR]), 128'(0));

    // randomized traffic in blocks of differing timeout
    busy_pct  = 20;
    stray_pct = 3;
    for (int b = 0; b < 6; b++) begin
      case (b)
        0: new_phase(1, 1, 0, 0);
        1: new_phase(1, 1, 0, 6);
        2: new_phase(1, 1, 0, 15);
        3: new_phase(1, 1, 0, 1);
        4: new_phase(1, 1, 0, 10);
        default: new_phase(1, 1, 0, 3);
      endcase
      for (int i = 0; i < 500; i++) step();
      drain($sformatf("random_%0d", b), 200);
    end
    busy_pct  = 0;
    stray_pct = 0;

    check("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_qspi_cmd_arbiter

// File: doc/qspi_cmd_arbiter.md
# qspi_cmd_arbiter

Shares the single command engine / QSPI FSM between two requesters: the CSR command path and the XIP read path. Latches the winning requester's command descriptor, issues a one-cycle start to the engine, and tracks the transaction to completion. Routes the done or timeout-error strobe back to the owning requester. Sits between the CSR block / XIP front-end and the command engine.

## Interface
Parameters:
- DESC_W, 96, width of the packed command descriptor: opcode, address, length, lanes, dummy, direction and related fields. Opaque to this block.
- STARVE_MAX, 4, consecutive XIP grants allowed while CSR is waiting.
- TO_W, 16, width of the timeout counter and threshold.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  system clock.
  - reset  in  1  asynchronous, active-high reset.
- CSR requester:
  - csr_req_i  in  1  CSR command request; level signal, held until csr_ack_o.
  - csr_desc_i  in  DESC_W  CSR descriptor; stable while csr_req_i is high.
  - csr_ack_o  out  1  pulse: descriptor accepted.
  - csr_done_o  out  1  pulse: CSR command completed.
  - csr_err_o  out  1  pulse: CSR command timed out.
- XIP requester:
  - xip_req_i, xip_desc_i, xip_ack_o, xip_done_o, xip_err_o  same meanings and widths as the CSR set, for the XIP requester.
- Configuration:
  - timeout_i  in  TO_W  watchdog threshold in clk cycles; 0 disables the watchdog.
- Engine side:
  - eng_start_o  out  1  one-cycle start pulse to the engine.
  - eng_desc_o  out  DESC_W  latched descriptor; held until the next grant.
  - eng_busy_i  in  1  engine busy.
  - eng_done_i  in  1  engine completion pulse.
  - eng_abort_o  out  1  pulse: force the engine/FSM to idle on timeout.
- Status:
  - owner_o  out  2  0 none, 1 CSR, 2 XIP.
  - busy_o  out  1  high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: arbitrates.
  - ISSUE: one cycle; start and ack are issued.
  - WAIT: waits for completion or timeout.
  - Every return goes to IDLE.
- Grant in IDLE only, and only when eng_busy_i=0 and at least one req is high.
- Priority:
  - XIP wins by default.
  - CSR wins if csr_req_i=1 and starve_cnt==STARVE_MAX.
  - CSR wins if it is the only requester.
- Starvation counter (3 bits min, saturating at STARVE_MAX):
  - Increments on an XIP grant while csr_req_i=1.
  - Clears on any CSR grant.
  - Clears on an XIP grant with csr_req_i=0.
- On grant:
  - eng_desc_o is latched from the winner's descriptor and owner_o is set.
  - Next state is ISSUE.
- ISSUE:
  - eng_start_o=1 and the winner's ack=1 for exactly this cycle.
  - The timeout counter is cleared.
  - Next state is WAIT.
- WAIT:
  - The counter increments every cycle.
  - If eng_done_i: the owner's done pulse fires, owner_o goes to 0, next state is IDLE.
  - Else if timeout_i≠0 and counter==timeout_i−1: eng_abort_o and the owner's err pulse fire, owner_o goes to 0, next state is IDLE.
  - eng_done_i in the same cycle as the timeout condition: done wins, with no abort and no err.
- req inputs are ignored outside IDLE.
- A requester drops req the cycle after its ack. If req is still high on return to IDLE, it is treated as a new request.
- eng_done_i outside WAIT is ignored.

## Timing
- Reset values: all outputs 0, including eng_desc_o=0 and owner_o=0. State IDLE, starve_cnt=0, timeout counter 0.
- Reset mid-transaction: immediate return to IDLE; no done, err or abort is emitted (the engine shares the reset).
- Latency:
  - req high in IDLE at cycle N → eng_start_o and ack at N+1.
  - eng_done_i at cycle M → owner done at M+1, IDLE at M+1, earliest next eng_start_o at M+2.
- Timeout: WAIT entered at cycle W → abort/err registered at W+timeout_i.
- All strobes are registered single-cycle pulses. At most one of done/err fires per transaction, and only toward the owner.

## Structure
- Package qspi_arb_pkg holds:
  - Owner encodings OWN_NONE/OWN_CSR/OWN_XIP.
  - State encodings ST_IDLE/ST_ISSUE/ST_WAIT.
  - Default DESC_W.
- Sub-module qspi_arb_watchdog: TO_W counter with clear, enable, threshold compare and disable-on-zero. Outputs an expire pulse.
- Everything else is flat in qspi_cmd_arbiter, roughly 200 lines.

## Test plan
- CSR only, csr_desc_i=0x…A5, eng_done_i 20 cycles after start → ack and start at N+1, eng_desc_o matches, owner_o=1, csr_done_o one cycle after eng_done_i, xip_* all stay 0.
- Both req high continuously, STARVE_MAX=4, each transaction done after 5 cycles → grant order XIP×4, CSR, XIP×4, CSR; starve_cnt returns to 0 after each CSR grant.
- timeout_i=10, no eng_done_i → eng_abort_o and err to owner exactly 10 cycles after WAIT entry; no done pulse; back to IDLE.
- timeout_i=10, eng_done_i on cycle 10 of WAIT → done pulse only, no abort, no err.
- eng_busy_i=1 while xip_req_i=1 → no grant until eng_busy_i falls; start occurs the cycle after it falls.
- reset asserted mid-WAIT with csr owner → all outputs 0 immediately; after release, a pending xip_req_i gets its start 1 cycle after the first IDLE sample.
